// File: rtl/video_out_ctrl.sv
// ============================================================================
// Module   : video_out_ctrl
// Brief    : Raster timing and FIFO read engine on video_clk. It expands
//            RGB565 FIFO words to RGB888 for the TMDS encoder.
//            Optional colour-bar generator: define VIDEO_OUT_TEST_PATTERN_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_out_ctrl #(
  parameter int          H_DISP   = 1280,
  parameter int          H_FP     = 110,
  parameter int          H_SYNC   = 40,
  parameter int          H_BP     = 220,
  parameter int          V_DISP   = 720,
  parameter int          V_FP     = 5,
  parameter int          V_SYNC   = 5,
  parameter int          V_BP     = 20,
  parameter int          RD_LAT   = 2,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1,
  parameter logic [23:0] UF_COLOR = 24'hFF00FF
) (
  input  logic        video_clk,
  input  logic        rst,
  input  logic        enable,
`ifdef VIDEO_OUT_TEST_PATTERN_EN
  input  logic        pattern_sel,
`endif
  output logic        fifo_rd_en,
  input  logic [15:0] pix_in,
  input  logic        pix_in_valid,
  output logic        frame_req,
  output logic        vid_hs,
  output logic        vid_vs,
  output logic        vid_de,
  output logic [23:0] vid_data,
  output logic        underflow,
  input  logic        underflow_clr
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] c_H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] c_H_DISP   = HW'(H_DISP);
  localparam logic [HW:0]   c_HS_START = (HW+1)'(H_DISP + H_FP);
  localparam logic [HW:0]   c_HS_END   = (HW+1)'(H_DISP + H_FP + H_SYNC);
  localparam logic [VW-1:0] c_V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] c_V_DISP   = VW'(V_DISP);
  localparam logic [VW-1:0] c_V_PRE_BL = VW'(V_DISP - 1);
  localparam logic [VW:0]   c_VS_START = (VW+1)'(V_DISP + V_FP);
  localparam logic [VW:0]   c_VS_END   = (VW+1)'(V_DISP + V_FP + V_SYNC);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [HW-1:0]   r_h_cnt;
  logic [VW-1:0]   r_v_cnt;
  logic            r_frame_req;
  logic            w_run;
  logic            w_h_last;
  logic            w_frame_last;
  logic            w_fr_set;
  logic            w_de_raw;
  logic            w_hs_raw;
  logic            w_vs_raw;
  logic [2:0]      r_dly [RD_LAT];
  logic            w_d_de;
  logic            w_d_hs;
  logic            w_d_vs;
  logic [23:0]     w_rgb;
  logic [23:0]     w_data_nxt;
  logic            w_uf;

  assign w_run        = (r_state == ST_RUN);
  assign w_h_last     = (r_h_cnt == c_H_LAST);
  assign w_frame_last = w_h_last && (r_v_cnt == c_V_LAST);

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Leaving RUN is only allowed on the last frame cycle so a frame is never cut short.
  always_comb begin
    w_state_nxt = r_state;
    w_fr_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state_nxt = ST_RUN;
          w_fr_set    = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_frame_last && !enable) w_state_nxt = ST_IDLE;
        // Registered one cycle early so the pulse lands on (h=0, v=V_DISP).
        if (w_h_last && (r_v_cnt == c_V_PRE_BL)) w_fr_set = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_frame_req <= 1'b0;
    end else begin
      r_frame_req <= w_fr_set;
      if (!w_run) begin
        r_h_cnt <= '0;
        r_v_cnt <= '0;
      end else if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end
  end

  assign frame_req  = r_frame_req;
  assign w_de_raw   = w_run && (r_h_cnt < c_H_DISP) && (r_v_cnt < c_V_DISP);
  assign w_hs_raw   = w_run && ({1'b0, r_h_cnt} >= c_HS_START) && ({1'b0, r_h_cnt} < c_HS_END);
  assign w_vs_raw   = w_run && ({1'b0, r_v_cnt} >= c_VS_START) && ({1'b0, r_v_cnt} < c_VS_END);
  assign fifo_rd_en = w_de_raw;

  // Timing is delayed by the FIFO read latency so delayed de meets pix_in_valid.
  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) r_dly[i] <= 3'b000;
    end else begin
      r_dly[0] <= {w_de_raw, w_hs_raw, w_vs_raw};
      for (int i = 1; i < RD_LAT; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  assign w_d_de = r_dly[RD_LAT-1][2];
  assign w_d_hs = r_dly[RD_LAT-1][1];
  assign w_d_vs = r_dly[RD_LAT-1][0];

  assign w_rgb = {pix_in[15:11], pix_in[15:13],
                  pix_in[10:5],  pix_in[10:9],
                  pix_in[4:0],   pix_in[4:2]};

`ifdef VIDEO_OUT_TEST_PATTERN_EN
  localparam int c_BAR_W = (H_DISP >= 8) ? (H_DISP / 8) : 1;

  logic [HW-1:0] r_bar_x;
  logic [31:0]   w_bar_q;
  logic [2:0]    w_bar_idx;
  logic [23:0]   w_bar_rgb;

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst)          r_bar_x <= '0;
    else if (!w_d_de) r_bar_x <= '0;
    else              r_bar_x <= r_bar_x + 1'b1;
  end

  assign w_bar_q   = 32'(r_bar_x) / c_BAR_W;
  assign w_bar_idx = (w_bar_q > 32'd7) ? 3'd7 : w_bar_q[2:0];

  always_comb begin
    w_bar_rgb = 24'h000000;
    case (w_bar_idx)
      3'd0: w_bar_rgb = 24'hFFFFFF;
      3'd1: w_bar_rgb = 24'hFFFF00;
      3'd2: w_bar_rgb = 24'h00FFFF;
      3'd3: w_bar_rgb = 24'h00FF00;
      3'd4: w_bar_rgb = 24'hFF00FF;
      3'd5: w_bar_rgb = 24'hFF0000;
      3'd6: w_bar_rgb = 24'h0000FF;
      default: w_bar_rgb = 24'h000000;
    endcase
  end

  assign w_uf = w_d_de && !pix_in_valid && !pattern_sel;

  always_comb begin
    w_data_nxt = 24'h000000;
    if (w_d_de) begin
      if (pattern_sel)       w_data_nxt = w_bar_rgb;
      else if (pix_in_valid) w_data_nxt = w_rgb;
      else                   w_data_nxt = UF_COLOR;
    end
  end
`else
  assign w_uf = w_d_de && !pix_in_valid;

  always_comb begin
    w_data_nxt = 24'h000000;
    if (w_d_de) w_data_nxt = pix_in_valid ? w_rgb : UF_COLOR;
  end
`endif

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      vid_de    <= 1'b0;
      vid_hs    <= ~HS_POL;
      vid_vs    <= ~VS_POL;
      vid_data  <= 24'h000000;
      underflow <= 1'b0;
    end else begin
      vid_de   <= w_d_de;
      vid_hs   <= w_d_hs ? HS_POL : ~HS_POL;
      vid_vs   <= w_d_vs ? VS_POL : ~VS_POL;
      vid_data <= w_data_nxt;
      if (w_uf)               underflow <= 1'b1;
      else if (underflow_clr) underflow <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: doc/video_out_ctrl.md
Name: video_out_ctrl

Overview:
- Display-side read engine on video_clk for the sorted-pixel async FIFO; the FIFO write side runs on PPL_clk.
- Generates raster timing for an H_DISP x V_DISP display.
- Issues FIFO read enables ahead of active video to cover the FIFO read latency, and expands RGB565 FIFO words to RGB888.
- Drives hsync/vsync/de/data to the HDMI/TMDS encoder. Also emits a per-frame request pulse so the pipeline prefills the FIFO during vertical blanking.

Parameters:
- H_DISP, 1280, active pixels per line
- H_FP, 110, horizontal front porch
- H_SYNC, 40, hsync width
- H_BP, 220, horizontal back porch
- V_DISP, 720, active lines
- V_FP, 5, vertical front porch
- V_SYNC, 5, vsync width
- V_BP, 20, vertical back porch
- RD_LAT, 2, cycles from fifo_rd_en to pix_in_valid (min 1)
- HS_POL, 1, active level of vid_hs
- VS_POL, 1, active level of vid_vs
- UF_COLOR, 24'hFF00FF, substitute pixel on underflow

Ports:
- video_clk, in, 1: pixel clock
- rst, in, 1: asynchronous, active-high reset
- enable, in, 1: run request
- fifo_rd_en, out, 1: FIFO read enable
- pix_in, in, 16: FIFO read data, {R[15:11], G[10:5], B[4:0]}
- pix_in_valid, in, 1: pix_in valid, RD_LAT cycles after fifo_rd_en
- frame_req, out, 1: one-cycle pulse; pipeline starts next frame
- vid_hs, out, 1: horizontal sync
- vid_vs, out, 1: vertical sync
- vid_de, out, 1: data enable
- vid_data, out, 24: RGB888 pixel
- underflow, out, 1: sticky underflow flag
- underflow_clr, in, 1: clears underflow

Behaviour:
- Reset values:
  - fifo_rd_en=0, frame_req=0, vid_de=0, vid_data=0, underflow=0
  - vid_hs=~HS_POL, vid_vs=~VS_POL
  - counters=0, FSM=IDLE, delay line cleared
- Totals: H_TOTAL=H_DISP+H_FP+H_SYNC+H_BP; V_TOTAL likewise. h_cnt/v_cnt widths are clog2 of the totals.
- Line order is active, FP, sync, BP. de_raw = (h_cnt<H_DISP)&&(v_cnt<V_DISP).
  - hs_raw when H_DISP+H_FP <= h_cnt < H_DISP+H_FP+H_SYNC.
  - vs_raw uses the same rule on v_cnt, for the whole line.
- Counter stepping: h_cnt wraps at H_TOTAL-1 and increments v_cnt; v_cnt wraps at V_TOTAL-1.
- FSM:
  - IDLE: counters held 0, all outputs inactive. Move to RUN when enable=1.
  - RUN: counters free-run. At the last cycle of the frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1) with enable=0, go to IDLE. Deasserting enable mid-frame never truncates the frame.
- frame_req: 1-cycle pulse on the IDLE->RUN transition cycle, and in RUN when h_cnt=0 && v_cnt=V_DISP (start of vertical blanking).
- fifo_rd_en = de_raw, combinational from the counters; exactly H_DISP reads per active line.
- de_raw/hs_raw/vs_raw pass through an RD_LAT-stage delay line, then one output register.
  - Total latency from counter position to vid_* is RD_LAT+1 cycles.
  - The delayed de aligns with pix_in_valid.
- RGB expansion:
  - R8={R5,R5[4:2]}
  - G8={G6,G6[5:4]}
  - B8={B5,B5[4:2]}
  - vid_data={R8,G8,B8}
- vid_data is 0 whenever vid_de=0.
- Underflow: delayed de=1 with pix_in_valid=0 -> vid_data=UF_COLOR for that pixel and underflow set.
  - underflow_clr clears the flag.
  - Set wins over clear in the same cycle.
  - Timing is never stretched on underflow.
- pix_in_valid=1 while delayed de=0 (excess data) is ignored and does not flag.
- Async reset mid-frame: immediate return to reset values; after release, wait for enable in IDLE.

Optional Feature:
- Macro VIDEO_OUT_TEST_PATTERN_EN. When defined:
  - Adds input pattern_sel (1 bit).
  - While pattern_sel=1, vid_data shows 8 vertical colour bars, each H_DISP/8 pixels wide. Order: white, yellow, cyan, green, magenta, red, blue, black.
  - fifo_rd_en still issued, so the FIFO drains; underflow is not flagged.
- When undefined: no pattern_sel port, no bar logic.

Test Plan:
Bench params: H_DISP=8, H_FP=2, H_SYNC=2, H_BP=2 (H_TOTAL 14); V_DISP=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL 7); RD_LAT=2.
- Release rst, enable=1, FIFO model always valid -> frame_req pulse on the first RUN cycle; 8 fifo_rd_en cycles per line for 4 lines; vid_de first high 3 cycles after the first rd_en; frame period 98 cycles.
- pix_in=16'hF800 then 16'h07E0 then 16'h001F -> vid_data=24'hFF0000, 24'h00FF00, 24'h0000FF; pix_in=16'h8410 -> 24'h848284.
- Sync check -> vid_hs=HS_POL for 2 cycles starting 10 cycles after line start (output-aligned); vid_vs=VS_POL for exactly 14 cycles per frame; second frame_req 56 cycles after line 0 start.
- Drop pix_in_valid for the 3rd pixel of line 1 -> that pixel = 24'hFF00FF, underflow=1 sticky; underflow_clr pulse -> 0; clr coincident with a new underflow -> stays 1.
- enable=0 at mid-frame -> frame completes all 4 active lines, then IDLE: no fifo_rd_en, vid_de=0, no further frame_req; re-enable -> new frame_req, restart at 0,0.
- Assert rst during an active line -> all outputs at reset values within the same cycle; no fifo_rd_en until enable is sampled after release.
